iob_uart_native: RTL and testbench
==================================

Name: iob_uart_native

Overview:
- Parametrised UART with a native IOb slave interface; the next generation of the IOb UART peripheral.
- No Wishbone bridge and no 16550 core.
- Adds configurable frame width, TX/RX FIFO depths, automatic RTS/CTS flow control, sticky error flags and a maskable interrupt.
- Sits on the system IOb bus as a console or peripheral UART.

Parameters:
- DATA_BITS, 8, frame data bits (5..8)
- STOP_BITS, 1, stop bits (1 or 2)
- TX_DEPTH_W, 4, log2 of TX FIFO depth (depth 16)
- RX_DEPTH_W, 4, log2 of RX FIFO depth (depth 16)
- RTS_MARGIN, 2, free RX slots at which RTS deasserts
- DIV_RST, 16'd868, reset value of the clocks-per-bit divisor

Ports:
- clk_i  in  1  system clock
- arst_n_i  in  1  asynchronous reset, active-low
- cke_i  in  1  clock enable; all state holds when 0
- iob_valid_i  in  1  request valid
- iob_addr_i  in  4  byte address (word-aligned)
- iob_wdata_i  in  32  write data
- iob_wstrb_i  in  4  write strobes; 0 = read
- iob_ready_o  out  1  request accepted
- iob_rvalid_o  out  1  read data valid
- iob_rdata_o  out  32  read data
- rs232_rxd_i  in  1  serial in
- rs232_txd_o  out  1  serial out
- rs232_cts_i  in  1  1 = peer may receive
- rs232_rts_o  out  1  1 = we may receive
- interrupt_o  out  1  level interrupt

Behaviour:
- Reset, outputs: txd_o=1, rts_o=1, interrupt_o=0, rvalid_o=0, rdata_o=0.
- Reset, state: FIFOs empty, flags 0, CTRL=0, DIV=DIV_RST.
- Clock/reset: one clock; reset is asynchronous, active-low.
- IOb handshake: iob_ready_o=1 constantly. A read accepted in cycle N gives rvalid_o=1 and rdata in cycle N+1 for exactly 1 cycle. Writes have no response.
- 0x0 DATA:
  - Write with wstrb[0] pushes wdata[DATA_BITS-1:0] into the TX FIFO. If TX is full the write is dropped and TX_OVF is set.
  - Read pops the RX FIFO. If RX is empty it returns 0 and does not pop.
- 0x4 STATUS (RO):
  - Bits: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] RX_OVR, [5] FRAME_ERR, [6] TX_OVF, [7] tx_busy.
  - [15:8] RX level, [23:16] TX level.
  - Sticky bits [6:4] clear when STATUS is read; a set event in the same cycle wins.
- 0x8 DIV (RW, [15:0]): clocks per bit; values <4 act as 4. A change takes effect at the next bit boundary.
- 0xC CTRL (RW): [0] tx_en, [1] rx_en, [2] flow_en, [3] rx_irq_en, [4] tx_irq_en, [5] err_irq_en, [6] tx_flush (self-clearing), [7] rx_flush (self-clearing).
- Other addresses read 0; writes to them are ignored.
- TX FSM, states IDLE->START->DATA->STOP->IDLE:
  - Leaves IDLE when tx_en && !tx_empty && (!flow_en || cts_sync).
  - Each state lasts DIV clocks. Data goes out LSB first. STOP lasts STOP_BITS*DIV clocks.
  - Pop occurs on entering START.
  - A CTS drop or tx_en=0 mid-frame does not abort the frame; it only blocks the next start.
- RX input: 2-flop synchronizer, reset to 1.
- RX FSM, states IDLE->START->DATA->STOP->IDLE:
  - IDLE: a falling edge with rx_en=1 enters START.
  - START: samples at DIV/2. If high, it is a false start and returns to IDLE.
  - DATA: samples every DIV clocks at mid-bit.
  - STOP: samples the first stop bit only. If 0, sets FRAME_ERR and discards the byte. Otherwise the byte is pushed; if RX is full the byte is dropped and RX_OVR is set.
  - After STOP, waits for the line to go high before returning to IDLE.
- Simultaneous push and pop on the same FIFO: both occur and the level is unchanged. A pop when full plus a push is legal.
- Flush: empties the FIFO at once. An in-flight TX frame completes.
- RTS: rts_o = !flow_en || (RX free slots > RTS_MARGIN), registered.
- Interrupt: interrupt_o is registered and equals (rx_irq_en && !rx_empty) || (tx_irq_en && tx_empty && !tx_busy) || (err_irq_en && |sticky).
- cke_i=0 freezes every register, including the bit counters.

Decomposition:
- Package iob_uart_native_pkg: register address constants, STATUS/CTRL bit indices, FSM state encodings, DIV_MIN=4.
- Sub-module iob_uart_native_fifo (parametrised W, DEPTH_W; push/pop/flush, full/empty/level), instantiated twice.

Test Plan:
- Loopback (txd->rxd), DIV=8, CTRL=0x03; write 0xA5, 0x3C → after about 2×10×8 clocks, STATUS[15:8]=2 and DATA reads return 0xA5 then 0x3C.
- TX waveform: DIV=4, write 0x55 → txd low 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high ≥4 clocks; tx_busy is 1 throughout.
- Overrun: with RX disabled from reading, receive 17 bytes → level=16 and RX_OVR=1; a STATUS read returns bit4=1 and the next read returns bit4=0.
- Frame error: inject a frame with stop=0 → FRAME_ERR=1, level unchanged; with err_irq_en=1, interrupt_o=1 until STATUS is read.
- Flow control: flow_en=1, cts=0, write 0x11 → txd stays 1; raise cts → frame starts within DIV+2 clocks.
- RTS: fill RX to 14 with RTS_MARGIN=2 → rts_o=0; one DATA read → rts_o=1 next cycle. Reset asserted mid-frame → txd=1 and FIFOs empty immediately.

Source files
------------

// File: rtl/iob_uart_native_pkg.sv
// Shared constants, register map and FSM encoding for the native-IOb UART.
package iob_uart_native_pkg;

  // Register word indices (byte address bits [3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_TX_EN      = 0;
  localparam int unsigned CTRL_RX_EN      = 1;
  localparam int unsigned CTRL_FLOW_EN    = 2;
  localparam int unsigned CTRL_RX_IRQ_EN  = 3;
  localparam int unsigned CTRL_TX_IRQ_EN  = 4;
  localparam int unsigned CTRL_ERR_IRQ_EN = 5;
  localparam int unsigned CTRL_TX_FLUSH   = 6;
  localparam int unsigned CTRL_RX_FLUSH   = 7;

  // STATUS sticky bit positions
  localparam int unsigned STAT_RX_OVR    = 4;
  localparam int unsigned STAT_FRAME_ERR = 5;
  localparam int unsigned STAT_TX_OVF    = 6;

  localparam logic [15:0] DIV_MIN = 16'd4;

  // StWait is only used by the receiver (line must return high before re-arming)
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWait} uart_st_e;

  // Divisors below DIV_MIN are treated as DIV_MIN
  function automatic logic [15:0] eff_div(logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/iob_uart_native_if.sv
// Native IOb bus bundle between the system master and the UART slave.
interface iob_uart_native_if;
  logic        valid;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rvalid, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rvalid, rdata);
endinterface

// File: rtl/iob_uart_native_fifo.sv
// First-word-fall-through FIFO with flush; push while full is accepted only with a pop.
module iob_uart_native_fifo #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEPTH_W = 4
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic               cke_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [W-1:0]       wdata_i,
  output logic [W-1:0]       rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [DEPTH_W:0]   level_o
);
  localparam int unsigned Depth = 1 << DEPTH_W;

  logic [W-1:0]       mem_q [Depth];
  logic [DEPTH_W-1:0] wptr_q, rptr_q;
  logic [DEPTH_W:0]   level_q, level_d;
  logic               do_push, do_pop;

  assign full_o  = level_q[DEPTH_W];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  // Occupancy next-state
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop)      level_d = level_q + (DEPTH_W+1)'(1);
    else if (!do_push && do_pop) level_d = level_q - (DEPTH_W+1)'(1);
  end

  // Pointers and level; flush wins over everything
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (cke_i) begin
      if (flush_i) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
      end else begin
        if (do_push) wptr_q <= wptr_q + DEPTH_W'(1);
        if (do_pop)  rptr_q <= rptr_q + DEPTH_W'(1);
        level_q <= level_d;
      end
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (cke_i && do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/iob_uart_native.sv
// UART with native IOb slave port, TX/RX FIFOs, RTS/CTS, sticky errors and interrupt.
module iob_uart_native
  import iob_uart_native_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned TX_DEPTH_W = 4,
  parameter int unsigned RX_DEPTH_W = 4,
  parameter int unsigned RTS_MARGIN = 2,
  parameter logic [15:0] DIV_RST    = 16'd868
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  iob_uart_native_if.slave iob,
  input  logic             rs232_rxd_i,
  output logic             rs232_txd_o,
  input  logic             rs232_cts_i,
  output logic             rs232_rts_o,
  output logic             interrupt_o
);
  localparam int unsigned RxDepth = 1 << RX_DEPTH_W;

  logic [5:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d, div_eff;
  logic [2:0]  sticky_q, sticky_d;
  logic        rvalid_q, rts_q, rts_d, irq_q, irq_d, txd_q, txd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rxd_s1_q, rxd_s2_q, rxd_prev_q, cts_s1_q, cts_s2_q;

  logic                  tx_pop, tx_full, tx_empty, tx_busy, tx_ovf_set;
  logic [DATA_BITS-1:0]  tx_head;
  logic [TX_DEPTH_W:0]   tx_level;
  logic                  rx_push, rx_full, rx_empty, rx_ovr_set, ferr_set;
  logic [DATA_BITS-1:0]  rx_head;
  logic [RX_DEPTH_W:0]   rx_level;

  uart_st_e              tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [15:0]           tx_cnt_q, tx_cnt_d, tx_bdiv_q, tx_bdiv_d;
  logic [15:0]           rx_cnt_q, rx_cnt_d, rx_bdiv_q, rx_bdiv_d;
  logic [2:0]            tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic                  tx_stop_q, tx_stop_d, tx_bnd, rx_bnd, rx_mid;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;

  // Bus decode
  logic       rd_en, wr_en, aligned, data_wr, div_wr, ctrl_wr, data_rd, status_rd;
  logic       tx_flush, rx_flush, unused_wdata;
  logic [1:0] reg_sel;

  assign reg_sel   = iob.addr[3:2];
  assign aligned   = (iob.addr[1:0] == 2'd0);
  assign rd_en     = iob.valid && (iob.wstrb == 4'd0);
  assign wr_en     = iob.valid && (iob.wstrb != 4'd0) && aligned;
  assign data_wr   = wr_en && (reg_sel == REG_DATA) && iob.wstrb[0];
  assign div_wr    = wr_en && (reg_sel == REG_DIV);
  assign ctrl_wr   = wr_en && (reg_sel == REG_CTRL) && iob.wstrb[0];
  assign data_rd   = rd_en && aligned && (reg_sel == REG_DATA);
  assign status_rd = rd_en && aligned && (reg_sel == REG_STATUS);
  assign tx_flush  = ctrl_wr && iob.wdata[CTRL_TX_FLUSH];
  assign rx_flush  = ctrl_wr && iob.wdata[CTRL_RX_FLUSH];
  assign unused_wdata = ^iob.wdata[31:16];

  assign iob.ready    = 1'b1;
  assign iob.rvalid   = rvalid_q;
  assign iob.rdata    = rdata_q;
  assign rs232_txd_o  = txd_q;
  assign rs232_rts_o  = rts_q;
  assign interrupt_o  = irq_q;

  assign div_eff    = eff_div(div_q);
  assign tx_busy    = (tx_st_q != StIdle);
  assign tx_ovf_set = data_wr && tx_full && !tx_pop;
  assign rx_ovr_set = rx_push && rx_full && !data_rd;
  assign tx_bnd     = (tx_cnt_q == tx_bdiv_q - 16'd1);
  assign rx_bnd     = (rx_cnt_q == rx_bdiv_q - 16'd1);
  assign rx_mid     = (rx_cnt_q == (rx_bdiv_q >> 1));

  iob_uart_native_fifo #(.W(DATA_BITS), .DEPTH_W(TX_DEPTH_W)) u_tx_fifo (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
    .push_i(data_wr), .pop_i(tx_pop), .flush_i(tx_flush),
    .wdata_i(iob.wdata[DATA_BITS-1:0]), .rdata_o(tx_head),
    .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
  );

  iob_uart_native_fifo #(.W(DATA_BITS), .DEPTH_W(RX_DEPTH_W)) u_rx_fifo (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
    .push_i(rx_push), .pop_i(data_rd), .flush_i(rx_flush),
    .wdata_i(rx_shift_q), .rdata_o(rx_head),
    .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
  );

  // Register writes, sticky flags, read mux, RTS and interrupt next-state
  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) ctrl_d = iob.wdata[5:0];
    div_d = div_q;
    if (div_wr && iob.wstrb[0]) div_d[7:0]  = iob.wdata[7:0];
    if (div_wr && iob.wstrb[1]) div_d[15:8] = iob.wdata[15:8];
    // A set in the same cycle as the clearing STATUS read wins
    sticky_d = (status_rd ? 3'b000 : sticky_q) | {tx_ovf_set, ferr_set, rx_ovr_set};
    rdata_d = '0;
    if (rd_en && aligned) begin
      unique case (reg_sel)
        REG_DATA:   if (!rx_empty) rdata_d[DATA_BITS-1:0] = rx_head;
        REG_STATUS: rdata_d = {8'd0, 8'(tx_level), 8'(rx_level), tx_busy, sticky_q,
                               tx_full, tx_empty, rx_full, rx_empty};
        REG_DIV:    rdata_d[15:0] = div_q;
        REG_CTRL:   rdata_d[5:0]  = ctrl_q;
        default:    rdata_d = '0;
      endcase
    end
    rts_d = !ctrl_q[CTRL_FLOW_EN] || (32'(rx_level) + RTS_MARGIN < RxDepth);
    irq_d = (ctrl_q[CTRL_RX_IRQ_EN] && !rx_empty) ||
            (ctrl_q[CTRL_TX_IRQ_EN] && tx_empty && !tx_busy) ||
            (ctrl_q[CTRL_ERR_IRQ_EN] && (sticky_q != 3'b000));
  end

  // Transmitter: bit period latched at each boundary so DIV changes apply per bit
  always_comb begin
    tx_st_d    = tx_st_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bdiv_d  = tx_bdiv_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    txd_d      = 1'b1;
    if (tx_st_q != StIdle) begin
      tx_cnt_d = tx_cnt_q + 16'd1;
      if (tx_bnd) begin
        tx_cnt_d  = '0;
        tx_bdiv_d = div_eff;
      end
    end
    unique case (tx_st_q)
      StIdle: begin
        if (ctrl_q[CTRL_TX_EN] && !tx_empty && (!ctrl_q[CTRL_FLOW_EN] || cts_s2_q)) begin
          tx_st_d    = StStart;
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = '0;
          tx_bdiv_d  = div_eff;
        end
      end
      StStart: begin
        txd_d = 1'b0;
        if (tx_bnd) begin
          tx_st_d  = StData;
          tx_bit_d = '0;
        end
      end
      StData: begin
        txd_d = tx_shift_q[0];
        if (tx_bnd) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == 3'(DATA_BITS - 1)) begin
            tx_st_d   = StStop;
            tx_stop_d = 1'b0;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (tx_bnd) begin
          if (tx_stop_q == 1'(STOP_BITS - 1)) tx_st_d = StIdle;
          else                                tx_stop_d = 1'b1;
        end
      end
      default: tx_st_d = StIdle;
    endcase
  end

  // Receiver: mid-bit sampling, first stop bit checked, then wait for idle line
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bdiv_d  = rx_bdiv_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    unique case (rx_st_q)
      StIdle: begin
        if (ctrl_q[CTRL_RX_EN] && rxd_prev_q && !rxd_s2_q) begin
          rx_st_d   = StStart;
          rx_cnt_d  = '0;
          rx_bdiv_d = div_eff;
        end
      end
      StStart: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_mid) begin
          rx_cnt_d = '0;
          if (rxd_s2_q) begin
            rx_st_d = StIdle;
          end else begin
            rx_st_d   = StData;
            rx_bit_d  = '0;
            rx_bdiv_d = div_eff;
          end
        end
      end
      StData: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_bnd) begin
          rx_cnt_d   = '0;
          rx_bdiv_d  = div_eff;
          rx_shift_d = {rxd_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == 3'(DATA_BITS - 1)) rx_st_d = StStop;
          else                               rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      StStop: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_bnd) begin
          if (rxd_s2_q) rx_push  = 1'b1;
          else          ferr_set = 1'b1;
          rx_st_d = StWait;
        end
      end
      StWait:  if (rxd_s2_q) rx_st_d = StIdle;
      default: rx_st_d = StIdle;
    endcase
  end

  // All state registers; cke_i low freezes everything
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ctrl_q <= '0;  div_q <= DIV_RST;  sticky_q <= '0;
      rvalid_q <= 1'b0;  rdata_q <= '0;  rts_q <= 1'b1;  irq_q <= 1'b0;  txd_q <= 1'b1;
      rxd_s1_q <= 1'b1;  rxd_s2_q <= 1'b1;  rxd_prev_q <= 1'b1;
      cts_s1_q <= 1'b1;  cts_s2_q <= 1'b1;
      tx_st_q <= StIdle;  tx_cnt_q <= '0;  tx_bdiv_q <= DIV_MIN;  tx_bit_q <= '0;
      tx_stop_q <= 1'b0;  tx_shift_q <= '0;
      rx_st_q <= StIdle;  rx_cnt_q <= '0;  rx_bdiv_q <= DIV_MIN;  rx_bit_q <= '0;
      rx_shift_q <= '0;
    end else if (cke_i) begin
      ctrl_q <= ctrl_d;  div_q <= div_d;  sticky_q <= sticky_d;
      rvalid_q <= rd_en;  rdata_q <= rdata_d;  rts_q <= rts_d;  irq_q <= irq_d;  txd_q <= txd_d;
      rxd_s1_q <= rs232_rxd_i;  rxd_s2_q <= rxd_s1_q;  rxd_prev_q <= rxd_s2_q;
      cts_s1_q <= rs232_cts_i;  cts_s2_q <= cts_s1_q;
      tx_st_q <= tx_st_d;  tx_cnt_q <= tx_cnt_d;  tx_bdiv_q <= tx_bdiv_d;  tx_bit_q <= tx_bit_d;
      tx_stop_q <= tx_stop_d;  tx_shift_q <= tx_shift_d;
      rx_st_q <= rx_st_d;  rx_cnt_q <= rx_cnt_d;  rx_bdiv_q <= rx_bdiv_d;  rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_iob_uart_native.sv
// Scoreboard bench: reads queue expected data, a negedge monitor checks every rvalid.
module tb_iob_uart_native;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic cke = 1'b1;
  logic rxd_drv = 1'b1;
  logic cts = 1'b1;
  logic loop_en = 1'b0;
  logic txd, rts, irq, rxd;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  rxm[$];

  iob_uart_native_if bus ();

  assign rxd = loop_en ? txd : rxd_drv;

  iob_uart_native dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .iob(bus),
    .rs232_rxd_i(rxd), .rs232_txd_o(txd), .rs232_cts_i(cts),
    .rs232_rts_o(rts), .interrupt_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every read response is matched against the oldest queued expectation
  always @(negedge clk) begin
    if (arst_n && bus.rvalid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rvalid: got rdata 0x%08h, expected no response", bus.rdata);
      end else begin
        check("rdata", bus.rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] st(int rxl, int txl, bit ovr, bit ferr, bit ovf, bit busy);
    logic [31:0] s;
    s = '0;
    s[0] = (rxl == 0);  s[1] = (rxl == 16);
    s[2] = (txl == 0);  s[3] = (txl == 16);
    s[4] = ovr;  s[5] = ferr;  s[6] = ovf;  s[7] = busy;
    s[15:8]  = rxl[7:0];
    s[23:16] = txl[7:0];
    return s;
  endfunction

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    bus.valid = 1'b1;  bus.addr = a;  bus.wdata = d;  bus.wstrb = 4'hF;
    @(negedge clk);
    bus.valid = 1'b0;  bus.wstrb = 4'h0;
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    bus.valid = 1'b1;  bus.addr = a;  bus.wstrb = 4'h0;
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  // Bit-banged frame into rxd at a fixed bit period, followed by two idle bit times
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int div);
    logic [9:0] f;
    f = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (div) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (2 * div) @(negedge clk);
  endtask

  task automatic model_rx(input logic [7:0] b, inout bit ovr);
    if (rxm.size() < 16) rxm.push_back(b);
    else ovr = 1'b1;
  endtask

  // Whole-frame txd check, one compare per clock, including trailing idle bit time
  task automatic tx_wave(input logic [7:0] b, input logic [15:0] divw, input int bl);
    logic [10:0] f;
    int t;
    f = {2'b11, b, 1'b0};
    bus_wr(4'h8, {16'h0, divw});
    bus_wr(4'hC, 32'h1);
    bus_wr(4'h0, {24'h0, b});
    t = 0;
    while (txd !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("tx_start", 32'(txd), 32'd0);
    for (int k = 0; k < 11 * bl; k++) begin
      check("tx_wave", 32'(txd), 32'(f[k / bl]));
      @(negedge clk);
    end
  endtask

  initial begin
    int n, div, t;
    bit ovr;
    logic [7:0] b;
    logic seen_low;

    bus.valid = 1'b0;  bus.addr = '0;  bus.wdata = '0;  bus.wstrb = '0;
    #12;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_rts", 32'(rts), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check("ready", 32'(bus.ready), 32'd1);
    bus_rd(4'h4, st(0, 0, 0, 0, 0, 0));
    bus_rd(4'h8, 32'd868);
    bus_rd(4'hC, 32'd0);
    bus_rd(4'h0, 32'd0);

    // Loopback rounds: first the fixed pair, then random counts, bytes and divisors
    loop_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      div = (r == 0) ? 8 : int'($urandom_range(4, 12));
      n   = (r == 0) ? 2 : int'($urandom_range(3, 16));
      bus_wr(4'h8, 32'(div));
      bus_wr(4'hC, 32'h3);
      for (int i = 0; i < n; i++) begin
        b = (r == 0) ? ((i == 0) ? 8'hA5 : 8'h3C) : 8'($urandom_range(0, 255));
        rxm.push_back(b);
        bus_wr(4'h0, {24'($urandom), b});
      end
      repeat (n * 10 * div + 4 * div + 20) @(negedge clk);
      bus_rd(4'h4, st(n, 0, 0, 0, 0, 0));
      for (int i = 0; i < n; i++) bus_rd(4'h0, {24'h0, rxm.pop_front()});
      bus_rd(4'h0, 32'd0);
    end
    loop_en = 1'b0;

    tx_wave(8'h55, 16'd4, 4);
    tx_wave(8'($urandom_range(0, 255)), 16'd2, 4);
    tx_wave(8'($urandom_range(0, 255)), 16'd6, 6);

    // TX overflow with transmitter disabled, then flush
    bus_wr(4'hC, 32'h0);
    for (int i = 0; i < 17; i++) bus_wr(4'h0, $urandom);
    bus_rd(4'h4, st(0, 16, 0, 0, 1, 0));
    bus_rd(4'h4, st(0, 16, 0, 0, 0, 0));
    bus_wr(4'hC, 32'h40);
    bus_rd(4'h4, st(0, 0, 0, 0, 0, 0));

    // Frame error with error interrupt enabled
    bus_wr(4'h8, 32'd8);
    bus_wr(4'hC, 32'h22);
    repeat (3) @(negedge clk);
    check("irq_idle", 32'(irq), 32'd0);
    send_frame(8'($urandom_range(0, 255)), 1'b0, 8);
    check("irq_ferr", 32'(irq), 32'd1);
    bus_rd(4'h4, st(0, 0, 0, 1, 0, 0));
    repeat (3) @(negedge clk);
    check("irq_ferr_clr", 32'(irq), 32'd0);

    // Overrun: 17 frames into a 16-deep FIFO
    bus_wr(4'hC, 32'h2);
    ovr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      model_rx(b, ovr);
      send_frame(b, 1'b1, 8);
    end
    bus_rd(4'h4, st(rxm.size(), 0, ovr, 0, 0, 0));
    bus_rd(4'h4, st(rxm.size(), 0, 0, 0, 0, 0));
    bus_wr(4'hC, 32'hA);
    repeat (3) @(negedge clk);
    check("irq_rx", 32'(irq), 32'd1);
    n = rxm.size();
    for (int i = 0; i < n; i++) bus_rd(4'h0, {24'h0, rxm.pop_front()});
    repeat (3) @(negedge clk);
    check("irq_rx_clr", 32'(irq), 32'd0);

    // RTS threshold
    bus_wr(4'hC, 32'h6);
    repeat (3) @(negedge clk);
    check("rts_empty", 32'(rts), 32'd1);
    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom_range(0, 255));
      rxm.push_back(b);
      send_frame(b, 1'b1, 8);
      if (i == 12) check("rts_13", 32'(rts), 32'd1);
    end
    check("rts_14", 32'(rts), 32'd0);
    bus_rd(4'h0, {24'h0, rxm.pop_front()});
    @(negedge clk);
    check("rts_after_pop", 32'(rts), 32'd1);
    n = rxm.size();
    for (int i = 0; i < n; i++) bus_rd(4'h0, {24'h0, rxm.pop_front()});

    // CTS flow control
    cts = 1'b0;
    bus_wr(4'hC, 32'h5);
    repeat (3) @(negedge clk);
    bus_wr(4'h0, 32'h11);
    seen_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (txd !== 1'b1) seen_low = 1'b1;
      @(negedge clk);
    end
    check("cts_block", 32'(seen_low), 32'd0);
    cts = 1'b1;
    t = 0;
    while (txd !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("cts_release", 32'(txd), 32'd0);
    bus_rd(4'h4, st(0, 0, 0, 0, 0, 1));
    repeat (100) @(negedge clk);

    // Asynchronous reset in the middle of a frame
    bus_wr(4'hC, 32'h1);
    for (int i = 0; i < 3; i++) bus_wr(4'h0, $urandom);
    t = 0;
    while (txd !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("mid_frame", 32'(txd), 32'd0);
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_txd", 32'(txd), 32'd1);
    check("arst_rts", 32'(rts), 32'd1);
    check("arst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    bus_rd(4'h4, st(0, 0, 0, 0, 0, 0));
    bus_rd(4'h8, 32'd868);
    repeat (5) @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
